fc_frame_tap_buffer: RTL and testbench
======================================

Name: fc_frame_tap_buffer

Overview:
- Parametrised successor to the fixed 10-output FC tap shift register.
- Collects NUM_TAPS serial samples from a fully-connected layer into one frame, then presents all taps in parallel on a flattened bus with a valid/ready handshake.
- Adds reset, sync clear, fill counting, backpressure and an optional running argmax for the classifier stage.
- Sits between the FC output serialiser and the classifier / result-capture logic.

Parameters:
- DATA_WIDTH, 32, sample width, two's-complement fixed point.
- NUM_TAPS, 10, samples per frame; legal range is 2 or more.
- CNT_W, $clog2(NUM_TAPS+1), width of fill_count.
- IDX_W, $clog2(NUM_TAPS), width of max_idx.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous frame abort.
- in_data  in  DATA_WIDTH  sample.
- in_valid  in  1  sample offered.
- in_ready  out  1  buffer accepts a sample.
- out_taps  out  NUM_TAPS*DATA_WIDTH  frame; slice k = [k*DATA_WIDTH +: DATA_WIDTH] is the k-th sample received in the frame (slice 0 is oldest).
- out_valid  out  1  a full frame is held.
- out_ready  in  1  consumer takes the frame.
- fill_count  out  CNT_W  samples captured in the current frame.
- max_val  out  DATA_WIDTH  largest sample of frame (ARGMAX_EN only).
- max_idx  out  IDX_W  slice index of max_val (ARGMAX_EN only).

Behaviour:
- Interface decision: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: all tap registers 0, fill_count 0, state FILL, out_valid 0, max_val 0, max_idx 0.
- Handshake terms:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- in_ready, combinational: 1 in FILL; equals out_ready in HOLD. It reads 1 immediately after reset.
- Shift on push:
  - Tap[k] <= tap[k+1] for k < NUM_TAPS-1.
  - Tap[NUM_TAPS-1] <= in_data.
  - After NUM_TAPS pushes, slice 0 holds the first sample and slice NUM_TAPS-1 holds the last.
- No push means all taps hold their values. in_valid gaps are allowed and insert no bubbles into the frame.
- State FILL:
  - Each push increments fill_count.
  - A push with fill_count == NUM_TAPS-1 sets fill_count = NUM_TAPS, moves to HOLD and sets out_valid = 1 on the same edge.
  - Latency: out_valid rises on the edge that captures the last sample.
- State HOLD:
  - out_taps, fill_count and max_* are stable while out_ready = 0.
  - pop without push: out_valid = 0, fill_count = 0, go to FILL. Taps are not cleared.
  - pop with push in the same cycle: the frame is consumed and the new sample is shifted in as sample 0 of the next frame. fill_count = 1, out_valid = 0, go to FILL.
  - No sample is lost or duplicated across back-to-back frames.
- Stale data: upper slices contain previous-frame data until overwritten. The consumer uses out_taps only while out_valid = 1.
- clear:
  - Has priority over push and pop.
  - Next edge: taps 0, fill_count 0, out_valid 0, state FILL, max_* 0.
  - A push in the same cycle is dropped.
- rst mid-frame or mid-HOLD: immediate return to the reset values; the partial frame is discarded.
- fill_count never exceeds NUM_TAPS and never wraps.

Optional Feature:
- Macro: ARGMAX_EN.
- When defined, max_val and max_idx ports and registers exist.
  - Each push in FILL, or a push during pop in HOLD, updates them.
  - First sample of a frame (effective count 0): load in_data with index 0.
  - Later samples: signed compare; if in_data > max_val (strict), load in_data with index = fill_count.
  - Ties keep the lowest index.
  - Values are final and valid when out_valid = 1.
- When undefined, both ports and all related logic are removed; other behaviour is identical.

Test Plan:
- Reset: assert rst asynchronously mid-cycle -> out_valid 0, fill_count 0, out_taps 0, in_ready 1 immediately.
- Basic frame: push 1..10 on consecutive cycles -> out_valid rises on the 10th edge; slice 0 = 1, slice 9 = 10; fill_count = 10.
- Gaps and backpressure: push 1..10 with in_valid idle on alternate cycles, hold out_ready = 0 for 5 cycles -> frame unchanged, in_ready = 0, an offered sample 99 is not taken; raise out_ready -> single pop, fill_count = 0.
- Back-to-back frames: out_ready and in_valid both high at the HOLD cycle with data 11 -> next frame slice 0 = 11; after 9 more pushes (12..20), slice 9 = 20.
- clear: push 4 samples then pulse clear together with in_valid -> fill_count 0, taps 0, that sample dropped; the following 10 pushes form a clean frame.
- ARGMAX_EN: frame {-5, 3, 7, 7, -1, 0, 2, 6, 7, -8} -> max_val 7, max_idx 2; all-negative frame {-9..-0} -> correct signed max, not unsigned.

Source files
------------

// File: rtl/fc_frame_tap_buffer.sv
// fc_frame_tap_buffer
// Collects NUM_TAPS serial samples from an FC layer into one frame and presents
// them in parallel behind a valid/ready handshake. Slice 0 of out_taps is the
// oldest sample of the frame. Upper slices may hold previous-frame data until
// they are overwritten, so out_taps is meaningful only while out_valid is high.
// Optional running argmax (max_val / max_idx) is built when ARGMAX_EN is defined.
module fc_frame_tap_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_TAPS   = 10,
    parameter int CNT_W      = $clog2(NUM_TAPS + 1),
    parameter int IDX_W      = $clog2(NUM_TAPS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] out_taps,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [CNT_W-1:0]               fill_count
`ifdef ARGMAX_EN
    ,
    output logic [DATA_WIDTH-1:0]          max_val,
    output logic [IDX_W-1:0]               max_idx
`endif
);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                         state_r;
    state_t                         state_s;
    logic [CNT_W-1:0]               cnt_r;
    logic [CNT_W-1:0]               cnt_s;
    logic [NUM_TAPS*DATA_WIDTH-1:0] taps_r;
    logic                           in_ready_s;
    logic                           push_s;
    logic                           pop_s;

    assign in_ready_s = (state_r == ST_FILL) ? 1'b1 : out_ready;
    assign push_s     = in_valid & in_ready_s;
    assign pop_s      = (state_r == ST_HOLD) & out_ready;

    assign in_ready   = in_ready_s;
    assign out_valid  = (state_r == ST_HOLD);
    assign out_taps   = taps_r;
    assign fill_count = cnt_r;

    // Next-state and fill-count logic; clear overrides push and pop
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        if (clear) begin
            state_s = ST_FILL;
            cnt_s   = {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_FILL: begin
                    if (push_s) begin
                        if (cnt_r == CNT_W'(NUM_TAPS - 1)) begin
                            state_s = ST_HOLD;
                            cnt_s   = CNT_W'(NUM_TAPS);
                        end else begin
                            cnt_s   = cnt_r + CNT_W'(1);
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                ST_HOLD: begin
                    if (pop_s) begin
                        state_s = ST_FILL;
                        // a sample pushed alongside the pop starts the next frame
                        cnt_s   = push_s ? CNT_W'(1) : {CNT_W{1'b0}};
                    end else begin
                        state_s = ST_HOLD;
                    end
                end
                default: begin
                    state_s = ST_FILL;
                    cnt_s   = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // State and fill-count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_FILL;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Tap shift register: newest sample enters at the top slice
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            taps_r <= {(NUM_TAPS*DATA_WIDTH){1'b0}};
        end else if (clear) begin
            taps_r <= {(NUM_TAPS*DATA_WIDTH){1'b0}};
        end else if (push_s) begin
            taps_r <= {in_data, taps_r[NUM_TAPS*DATA_WIDTH-1:DATA_WIDTH]};
        end
    end

`ifdef ARGMAX_EN
    logic [DATA_WIDTH-1:0] max_val_r;
    logic [IDX_W-1:0]      max_idx_r;
    logic                  first_s;
    logic                  greater_s;

    // First-sample and strict signed-greater detection for the running max
    always_comb begin
        first_s   = 1'b0;
        greater_s = 1'b0;
        if (state_r == ST_HOLD) begin
            first_s = 1'b1;
        end else begin
            first_s = (cnt_r == {CNT_W{1'b0}});
        end
        greater_s = ($signed(in_data) > $signed(max_val_r));
    end

    // Running max register; ties keep the earlier (lower) index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_val_r <= {DATA_WIDTH{1'b0}};
            max_idx_r <= {IDX_W{1'b0}};
        end else if (clear) begin
            max_val_r <= {DATA_WIDTH{1'b0}};
            max_idx_r <= {IDX_W{1'b0}};
        end else if (push_s) begin
            if (first_s) begin
                max_val_r <= in_data;
                max_idx_r <= {IDX_W{1'b0}};
            end else if (greater_s) begin
                max_val_r <= in_data;
                max_idx_r <= IDX_W'(cnt_r);
            end
        end
    end

    assign max_val = max_val_r;
    assign max_idx = max_idx_r;
`endif

endmodule

// File: tb/tb_fc_frame_tap_buffer.sv
// Testbench for fc_frame_tap_buffer: table-driven cycle vectors with a frame
// scoreboard, followed by hand-written reset, clear and argmax sequences.
module tb_fc_frame_tap_buffer;

    localparam int DW = 32;
    localparam int NT = 10;
    localparam int CW = $clog2(NT + 1);
    localparam int IW = $clog2(NT);

    logic           clk = 1'b0;
    logic           rst;
    logic           clear;
    logic [DW-1:0]  in_data;
    logic           in_valid;
    logic           in_ready;
    logic [NT*DW-1:0] out_taps;
    logic           out_valid;
    logic           out_ready;
    logic [CW-1:0]  fill_count;
`ifdef ARGMAX_EN
    logic [DW-1:0]  max_val;
    logic [IW-1:0]  max_idx;
`endif

    fc_frame_tap_buffer #(.DATA_WIDTH(DW), .NUM_TAPS(NT)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_taps   (out_taps),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .fill_count (fill_count)
`ifdef ARGMAX_EN
        ,
        .max_val    (max_val),
        .max_idx    (max_idx)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic          ordy;
        logic          clr;
        logic          e_rdy;
        logic          e_ov;
        logic [CW-1:0] e_fc;
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [NT*DW-1:0] cur_frame;
    int               cur_n = 0;
    logic [NT*DW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_taps(input string name, input logic [NT*DW-1:0] act, input logic [NT*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic v, input int d, input logic ordy, input logic clr,
                       input logic e_rdy, input logic e_ov, input int e_fc);
        vec_t x;
        x.v = v; x.d = DW'(d); x.ordy = ordy; x.clr = clr;
        x.e_rdy = e_rdy; x.e_ov = e_ov; x.e_fc = CW'(e_fc);
        vecs.push_back(x);
    endtask

    // Scoreboard step, called before the edge with the applied vector
    task automatic sb_cycle(input vec_t x);
        if (exp_q.size() > 0) begin
            chk_taps("sb_frame", out_taps, exp_q[0]);
        end
        if (x.clr) begin
            cur_n = 0;
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0 && x.ordy) begin
                void'(exp_q.pop_front());
            end
            if (x.v && x.e_rdy) begin
                cur_frame[cur_n*DW +: DW] = x.d;
                cur_n++;
                if (cur_n == NT) begin
                    exp_q.push_back(cur_frame);
                    cur_n = 0;
                end
            end
        end
    endtask

    task automatic drive(input logic v, input int d, input logic ordy, input logic clr);
        in_valid  = v;
        in_data   = DW'(d);
        out_ready = ordy;
        clear     = clr;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clear     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals_a[NT];
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        cur_frame = '0;

        // Basic frame 1..10, short hold, then pop
        for (int k = 1; k <= NT; k++) add(1'b1, k, 1'b0, 1'b0, 1'b1, (k == NT), k);
        for (int k = 0; k < 2; k++) add(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, NT);
        add(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        // Gapped frame, 5 cycles of backpressure with 99 offered, then pop
        for (int k = 1; k <= NT; k++) begin
            add(1'b1, k, 1'b0, 1'b0, 1'b1, (k == NT), k);
            if (k < NT) add(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0, k);
        end
        for (int k = 0; k < 5; k++) add((k == 2), 99, 1'b0, 1'b0, 1'b0, 1'b1, NT);
        add(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        // Back-to-back frames: pop together with push of 11
        for (int k = 1; k <= NT; k++) add(1'b1, k, 1'b0, 1'b0, 1'b1, (k == NT), k);
        add(1'b1, 11, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        for (int k = 12; k <= 20; k++) add(1'b1, k, 1'b0, 1'b0, 1'b1, (k == 20), k - 10);
        add(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
        // Clear after 4 samples drops the concurrent push; clean frame follows
        for (int k = 1; k <= 4; k++) add(1'b1, 30 + k, 1'b0, 1'b0, 1'b1, 1'b0, k);
        add(1'b1, 77, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        for (int k = 1; k <= NT; k++) add(1'b1, 40 + k, 1'b0, 1'b0, 1'b1, (k == NT), k);
        add(1'b0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 0);

        #12;
        rst = 1'b0;
        #1;
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_fill", fill_count, '0);
        chk("reset_in_ready", in_ready, 1'b1);
        chk_taps("reset_taps", out_taps, '0);
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            in_valid  = vecs[i].v;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            clear     = vecs[i].clr;
            @(negedge clk);
            chk($sformatf("in_ready[%0d]", i), in_ready, vecs[i].e_rdy);
            sb_cycle(vecs[i]);
            @(posedge clk);
            #1;
            chk($sformatf("out_valid[%0d]", i), out_valid, vecs[i].e_ov);
            chk($sformatf("fill_count[%0d]", i), fill_count, vecs[i].e_fc);
        end
        in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0;
        chk("sb_drained", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset mid-cycle while a full frame is held
        for (int k = 1; k <= NT; k++) drive(1'b1, 200 + k, 1'b0, 1'b0);
        chk("hold_before_rst", out_valid, 1'b1);
        chk("hold_in_ready", in_ready, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_out_valid", out_valid, 1'b0);
        chk("async_rst_fill", fill_count, '0);
        chk("async_rst_in_ready", in_ready, 1'b1);
        chk_taps("async_rst_taps", out_taps, '0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Clear mid-fill zeroes taps; clear in HOLD drops the frame
        for (int k = 1; k <= 3; k++) drive(1'b1, k + 4, 1'b0, 1'b0);
        drive(1'b1, 55, 1'b0, 1'b1);
        chk("clear_fill", fill_count, '0);
        chk_taps("clear_taps", out_taps, '0);
        for (int k = 1; k <= NT; k++) drive(1'b1, k, 1'b0, 1'b0);
        chk("clear_hold_pre", out_valid, 1'b1);
        drive(1'b0, 0, 1'b1, 1'b1);
        chk("clear_hold_valid", out_valid, 1'b0);
        chk("clear_hold_fill", fill_count, '0);
        chk_taps("clear_hold_taps", out_taps, '0);

`ifdef ARGMAX_EN
        chk("clear_max_val", max_val, '0);
        vals_a = '{-5, 3, 7, 7, -1, 0, 2, 6, 7, -8};
        for (int k = 0; k < NT; k++) drive(1'b1, vals_a[k], 1'b0, 1'b0);
        chk("argmax_valid", out_valid, 1'b1);
        chk("argmax_val", max_val, DW'(7));
        chk("argmax_idx", max_idx, IW'(2));
        // Pop together with the first sample of the all-negative frame
        drive(1'b1, -9, 1'b1, 1'b0);
        for (int k = 1; k < NT; k++) drive(1'b1, k - 9, 1'b0, 1'b0);
        chk("argmax_neg_valid", out_valid, 1'b1);
        chk("argmax_neg_val", max_val, DW'(0));
        chk("argmax_neg_idx", max_idx, IW'(9));
        drive(1'b0, 0, 1'b1, 1'b0);
        chk("argmax_pop", out_valid, 1'b0);
`else
        vals_a = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        chk("idle_in_ready", in_ready, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
